jk_cmd_driver: RTL and testbench

Command sequencer that sits directly upstream of the team's JK flip-flop and drives its J/K inputs. It accepts HOLD/RESET/SET/TOGGLE commands with a repeat count over a valid/ready handshake and buffers them in a small FIFO. It plays each command onto J/K for the requested number of cycles and checks the flip-flop's Q, fed back on q_fb, against an internal expected-state model.

---
 rtl/jk_drv_pkg.sv | 15 +
 rtl/jk_cmd_driver_if.sv | 11 +
 rtl/jk_cmd_fifo.sv | 40 ++++
 rtl/jk_cmd_driver.sv | 108 ++++++++++
 tb/tb_jk_cmd_driver.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: op codes, FSM states and command record shared by the JK command driver
// Contents: OP_* codes ({J,K} values), state_t FSM encoding, cmd_t FIFO word.
package jk_drv_pkg;
    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;
    // Widest repeat field the command record can carry; narrower CNT_W zero-extends.
    localparam int CNT_W_MAX = 16;
    typedef enum logic {IDLE, DRIVE} state_t;
    typedef struct packed {
        logic [1:0]           op;
        logic [CNT_W_MAX-1:0] rep;
    } cmd_t;
endpackage

// File: rtl/jk_cmd_driver_if.sv
// jk_cmd_driver_if: valid/ready command channel into the JK command driver
// Signals: cmd_valid/cmd_op/cmd_rep from the producer, cmd_ready back from the driver.
// Modports: master (producer side), slave (driver side).
interface jk_cmd_driver_if #(parameter int CNT_W = 4);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_rep;
    modport master (output cmd_valid, cmd_op, cmd_rep, input cmd_ready);
    modport slave (input cmd_valid, cmd_op, cmd_rep, output cmd_ready);
endinterface

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: synchronous FIFO with wrap-bit pointers and full/empty flags
// Ports: clk, rst (sync, active-high), flush (sync clear), push/din, pop/dout (show-ahead head),
//        full, empty.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, rp_q;
    logic         wr, rd;
    assign empty = wp_q == rp_q;
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign rd    = pop && !empty;
    // A pop frees the head slot at the same edge, so a push is still taken when full.
    assign wr    = push && (!full || rd);
    assign dout  = mem_q[rp_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + (AW+1)'(1);
            if (rd) rp_q <= rp_q + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: plays queued HOLD/RESET/SET/TOGGLE commands onto a JK flip-flop and checks its Q
// Ports: clk, rst (sync, active-high); cmd (command channel, slave); abort (flush + stop);
//        j/k (registered drive); q_fb (flip-flop Q); busy; exp_valid/exp_q (expected-Q model);
//        err_pulse/err_cnt (one-cycle mismatch flag and saturating count).
module jk_cmd_driver
    import jk_drv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    jk_cmd_driver_if.slave   cmd,
    input  logic             abort,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             busy,
    output logic             exp_valid,
    output logic             exp_q,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [1:0]       jk_q, jk_d;
    logic             eq_q, eq_d, ev_q, ev_d, pend_q, pend_d, err_q, err_d;
    logic [ERR_W-1:0] cnt_q;
    logic             full, empty, pop, push;
    cmd_t             push_cmd, head;
    assign push_cmd      = '{op: cmd.cmd_op, rep: CNT_W_MAX'(cmd.cmd_rep)};
    assign cmd.cmd_ready = !rst && !full;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    jk_cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (push),
        .pop   (pop),
        .din   (push_cmd),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    // The last drive cycle of a command doubles as the load slot for the next, so back-to-back
    // commands play without a gap.
    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        jk_d    = jk_q;
        pop     = 1'b0;
        if (state_q == IDLE || rep_q == '0) begin
            pop     = !empty;
            state_d = empty ? IDLE : DRIVE;
            jk_d    = empty ? OP_HOLD : head.op;
            rep_d   = empty ? rep_q : CNT_W'(head.rep);
        end else begin
            rep_d = rep_q - CNT_W'(1);
        end
        if (abort) begin
            state_d = IDLE;
            jk_d    = OP_HOLD;
            pop     = 1'b0;
        end
    end
    // Expected Q follows the J/K pair that was active across this edge.
    always_comb begin
        eq_d   = eq_q;
        ev_d   = ev_q;
        pend_d = 1'b0;
        if (state_q == DRIVE) begin
            eq_d   = jk_q == OP_RESET ? 1'b0 : jk_q == OP_SET ? 1'b1 : jk_q == OP_TOGGLE ? !eq_q : eq_q;
            ev_d   = ev_q || jk_q == OP_RESET || jk_q == OP_SET;
            pend_d = ev_d;
        end
    end
    // q_fb only reflects a drive edge one cycle later, hence the pending flag.
    assign err_d = pend_q && (q_fb != eq_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rep_q   <= '0;
            jk_q    <= OP_HOLD;
            eq_q    <= 1'b0;
            ev_q    <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            jk_q    <= jk_d;
            eq_q    <= eq_d;
            ev_q    <= ev_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            cnt_q   <= cnt_q + ERR_W'(err_d && cnt_q != '1);
        end
    end
    assign j         = jk_q[1];
    assign k         = jk_q[0];
    assign busy      = !empty || state_q == DRIVE;
    assign exp_valid = ev_q;
    assign exp_q     = eq_q;
    assign err_pulse = err_q;
    assign err_cnt   = cnt_q;
endmodule

// File: tb/tb_jk_cmd_driver.sv
// tb_jk_cmd_driver: randomized scoreboard bench for jk_cmd_driver against a command-queue model
// Drives commands through the interface, models a real JK flip-flop (with optional stuck Q),
// and compares every DUT output each cycle against expectations queued by the model.
module tb_jk_cmd_driver;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int ERR_W = 8;

    typedef struct {
        logic       j, k, busy, ev, eq, ep;
        logic [7:0] ec;
        bit         nfull;
    } exp_t;
    typedef struct {
        int op;
        int rep;
    } cmd_m_t;

    logic clk = 0, rst = 1, abort = 0;
    logic j, k, q_fb, busy, exp_valid, exp_q, err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic q_ff = 0;
    bit stuck = 0, stuck_v = 0;
    int ncmp = 0, nfail = 0;
    exp_t sb[$];

    jk_cmd_driver_if #(.CNT_W(CNT_W)) bus ();

    jk_cmd_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (bus),
        .abort     (abort),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .exp_valid (exp_valid),
        .exp_q     (exp_q),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    always #5 clk = !clk;

    // The flip-flop being driven.
    always @(posedge clk) begin
        if (rst) q_ff <= 1'b0;
        else q_ff <= {j, k} == 2'b01 ? 1'b0 : {j, k} == 2'b10 ? 1'b1 : {j, k} == 2'b11 ? !q_ff : q_ff;
    end
    assign q_fb = stuck ? stuck_v : q_ff;

    // Reference model: a queue of waiting commands plus the cycles left of the one playing.
    initial begin
        cmd_m_t cmdq[$];
        cmd_m_t c;
        int cur_op = 0, cur_left = 0, ec = 0;
        bit act = 0, mq = 0, mv = 0, pend = 0, ep = 0, full_before;
        exp_t r;
        forever begin
            @(posedge clk);
            if (rst) begin
                cmdq.delete();
                cur_left = 0; act = 0; mq = 0; mv = 0; pend = 0; ep = 0; ec = 0;
            end else begin
                ep = pend && (q_fb !== mq);
                if (ep && ec < 255) ec++;
                pend = 0;
                if (act) begin
                    if (cur_op == 1) begin mq = 0; mv = 1; end
                    else if (cur_op == 2) begin mq = 1; mv = 1; end
                    else if (cur_op == 3) mq = !mq;
                    pend = mv;
                end
                full_before = cmdq.size() >= DEPTH;
                if (abort) begin
                    cmdq.delete();
                    cur_left = 0;
                end else begin
                    if (cur_left == 0 && cmdq.size() > 0) begin
                        c = cmdq.pop_front();
                        cur_op = c.op;
                        cur_left = c.rep + 1;
                    end
                    if (bus.cmd_valid && !full_before) cmdq.push_back('{int'(bus.cmd_op), int'(bus.cmd_rep)});
                end
                act = cur_left > 0;
                if (act) cur_left--;
            end
            r.j = act && cur_op[1];
            r.k = act && cur_op[0];
            r.busy = act || cmdq.size() > 0;
            r.ev = mv;
            r.eq = mq;
            r.ep = ep;
            r.ec = 8'(ec);
            r.nfull = cmdq.size() < DEPTH;
            sb.push_back(r);
        end
    end

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        ncmp++;
        if (act_v !== exp_v) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act_v, exp_v);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                chk("j", 32'(j), 32'(r.j));
                chk("k", 32'(k), 32'(r.k));
                chk("busy", 32'(busy), 32'(r.busy));
                chk("exp_valid", 32'(exp_valid), 32'(r.ev));
                chk("exp_q", 32'(exp_q), 32'(r.eq));
                chk("err_pulse", 32'(err_pulse), 32'(r.ep));
                chk("err_cnt", 32'(err_cnt), 32'(r.ec));
                chk("cmd_ready", 32'(bus.cmd_ready), 32'(r.nfull && !rst));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int op, input int rep);
        bit acc = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'(op);
        bus.cmd_rep = CNT_W'(rep);
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (!acc) begin
            ncmp++;
            nfail++;
            $display("FAIL push_timeout at %0t: cmd_ready stayed 0, expected 1 within 100 cycles", $time);
        end
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int n = 0; n < 600 && !idle; n++) begin
            @(negedge clk);
            idle = !busy;
            @(posedge clk);
            #1;
        end
        if (!idle) begin
            ncmp++;
            nfail++;
            $display("FAIL idle_timeout at %0t: busy stayed 1, expected 0 within 600 cycles", $time);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_rep = '0;
        cyc(2);
        rst = 0;
        push(2, 0);
        wait_idle();
        cyc(3);
        push(1, 0);
        push(3, 3);
        push(0, 1);
        wait_idle();
        cyc(2);
        push(2, 15);
        for (int i = 0; i < 5; i++) push(i % 4, i);
        wait_idle();
        rst = 1;
        cyc(1);
        rst = 0;
        stuck = 1;
        stuck_v = 1;
        push(3, 2);
        wait_idle();
        cyc(3);
        stuck_v = 0;
        for (int i = 0; i < 260; i++) push(2, 0);
        wait_idle();
        cyc(3);
        stuck = 0;
        rst = 1;
        cyc(1);
        rst = 0;
        push(2, 0);
        push(3, 7);
        push(0, 2);
        push(1, 1);
        cyc(3);
        abort = 1;
        cyc(1);
        abort = 0;
        cyc(3);
        push(2, 10);
        cyc(3);
        rst = 1;
        cyc(1);
        rst = 0;
        cyc(2);
        for (int i = 0; i < 400; i++) begin
            push(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            cyc(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 15) == 0) begin
                abort = 1;
                cyc(1);
                abort = 0;
            end
            if ($urandom_range(0, 7) == 0) begin
                stuck = !stuck;
                stuck_v = 1'($urandom_range(0, 1));
            end
        end
        wait_idle();
        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
